// File: rtl/la_step_sequence_checker.sv
// Synthesisable firmware step-sequence checker: tracks step_i/status_i, reports pass/fail/current step.
// Optional build macro: LA_STEP_STRICT_ORDER_EN (out-of-order step codes fail immediately with code 10).
module la_step_sequence_checker #(
  parameter int                   NUM_STEPS   = 17,
  parameter int                   STEP_W      = 6,
  parameter int                   STAT_W      = 2,
  parameter logic [NUM_STEPS-1:0] SKIP_MASK   = 17'h00011,
  parameter int                   TIMEOUT     = 200000,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [STAT_W-1:0] status_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [1:0]        fail_code_o,
  output logic [STEP_W-1:0] cur_step_o,
  output logic [STEP_W-1:0] fail_step_o
);

  localparam int                  CNT_W     = $clog2(TIMEOUT + 1);
  localparam int                  MASK_W    = 1 << STEP_W;
  localparam logic [MASK_W-1:0]   SKIP_FULL = MASK_W'(SKIP_MASK);
  localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [1:0]          CODE_TIMEOUT = 2'b01;
  localparam logic [1:0]          CODE_ORDER   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_STEP,
    S_WAIT_STAT,
    S_PASS,
    S_FAIL
  } state_t;

  // state_q is the observable FSM state for bound checkers.
  state_t                               state_q, state_d;
  logic [STEP_W-1:0]                    exp_q, exp_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [1:0]                           fail_code_q, fail_code_d;
  logic [STEP_W-1:0]                    fail_step_q, fail_step_d;
  logic [SYNC_STAGES-1:0][STEP_W-1:0]   step_sync_q, step_sync_d;
  logic [SYNC_STAGES-1:0][STAT_W-1:0]   stat_sync_q, stat_sync_d;

  logic [STEP_W-1:0] s_step;
  logic [STAT_W-1:0] s_stat;
  logic              busy;
  logic              step_hit;
  logic              stat_idle;
  logic              timed_out;
  logic              skip_cur;
  logic              is_last;
  logic              order_bad;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    step_sync_d = {step_sync_q[SYNC_STAGES-2:0], step_i};
    stat_sync_d = {stat_sync_q[SYNC_STAGES-2:0], status_i};
  end

  assign s_step    = step_sync_q[SYNC_STAGES-1];
  assign s_stat    = stat_sync_q[SYNC_STAGES-1];
  assign busy      = (state_q == S_WAIT_STEP) || (state_q == S_WAIT_STAT);
  assign step_hit  = (s_step == exp_q);
  assign stat_idle = (s_stat == '0);
  assign timed_out = (cnt_q == CNT_LAST);
  assign skip_cur  = SKIP_FULL[exp_q];
  assign is_last   = (exp_q == LAST_STEP);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef LA_STEP_STRICT_ORDER_EN
  // A still-held previous code is legal; anything else is out of order.
  assign order_bad = !(step_hit || ((exp_q != '0) && (s_step == exp_q - STEP_W'(1))));
`else
  assign order_bad = 1'b0;
`endif

  // start_i/abort_i are single-cycle requests sampled on every edge; abort wins, start is ignored while busy.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    fail_code_d = fail_code_q;
    fail_step_d = fail_step_q;
    if (abort_i) begin
      state_d     = S_IDLE;
      exp_d       = '0;
      cnt_d       = '0;
      fail_code_d = 2'b00;
      fail_step_d = '0;
    end else if (start_i && !busy) begin
      state_d     = S_WAIT_STEP;
      exp_d       = '0;
      cnt_d       = '0;
      fail_code_d = 2'b00;
      fail_step_d = '0;
    end else begin
      case (state_q)
        S_WAIT_STEP: begin
          if (timed_out) begin
            state_d     = S_FAIL;
            cnt_d       = '0;
            fail_code_d = CODE_TIMEOUT;
            fail_step_d = exp_q;
          end else if (order_bad) begin
            state_d     = S_FAIL;
            cnt_d       = '0;
            fail_code_d = CODE_ORDER;
            fail_step_d = exp_q;
          end else if (step_hit) begin
            cnt_d = '0;
            if (is_last && (skip_cur || stat_idle)) begin
              state_d = S_PASS;
            end else if (skip_cur) begin
              exp_d = exp_q + STEP_W'(1);
            end else begin
              state_d = S_WAIT_STAT;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT_STAT: begin
          if (timed_out) begin
            state_d     = S_FAIL;
            cnt_d       = '0;
            fail_code_d = CODE_TIMEOUT;
            fail_step_d = exp_q;
          end else if (stat_idle) begin
            cnt_d = '0;
            if (is_last) begin
              state_d = S_PASS;
            end else begin
              state_d = S_WAIT_STEP;
              exp_d   = exp_q + STEP_W'(1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      exp_q       <= '0;
      cnt_q       <= '0;
      fail_code_q <= 2'b00;
      fail_step_q <= '0;
      step_sync_q <= '0;
      stat_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      fail_code_q <= fail_code_d;
      fail_step_q <= fail_step_d;
      step_sync_q <= step_sync_d;
      stat_sync_q <= stat_sync_d;
    end
  end

  assign busy_o      = busy;
  assign pass_o      = (state_q == S_PASS);
  assign fail_o      = (state_q == S_FAIL);
  assign fail_code_o = fail_code_q;
  assign cur_step_o  = exp_q;
  assign fail_step_o = fail_step_q;

endmodule

// File: tb/tb_la_step_sequence_checker.sv
// Self-checking bench for la_step_sequence_checker: vector table plus hand-written multi-cycle sequences.
module tb_la_step_sequence_checker;

  localparam int          NUM_STEPS   = 17;
  localparam int          STEP_W      = 6;
  localparam int          STAT_W      = 2;
  localparam logic [16:0] SKIP_MASK   = 17'h00011;
  localparam int          TIMEOUT     = 100;
  localparam int          SYNC_STAGES = 2;
  localparam int          OUT_W       = 3 + 2 + 2 * STEP_W;

  logic              clk;
  logic              wb_rst_i;
  logic              start_i;
  logic              abort_i;
  logic [STEP_W-1:0] step_i;
  logic [STAT_W-1:0] status_i;
  logic              busy_o;
  logic              pass_o;
  logic              fail_o;
  logic [1:0]        fail_code_o;
  logic [STEP_W-1:0] cur_step_o;
  logic [STEP_W-1:0] fail_step_o;

  la_step_sequence_checker #(
    .NUM_STEPS  (NUM_STEPS),
    .STEP_W     (STEP_W),
    .STAT_W     (STAT_W),
    .SKIP_MASK  (SKIP_MASK),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .step_i     (step_i),
    .status_i   (status_i),
    .busy_o     (busy_o),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .fail_code_o(fail_code_o),
    .cur_step_o (cur_step_o),
    .fail_step_o(fail_step_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  string            name_q[$];

  function automatic logic [OUT_W-1:0] pack(input logic busy, input logic pass, input logic fail,
                                            input logic [1:0] code, input logic [STEP_W-1:0] cur,
                                            input logic [STEP_W-1:0] fstep);
    return {busy, pass, fail, code, cur, fstep};
  endfunction

  task automatic expect_out(input string nm, input logic [OUT_W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_out();
    logic [OUT_W-1:0] e;
    logic [OUT_W-1:0] a;
    string            nm;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = pack(busy_o, pass_o, fail_o, fail_code_o, cur_step_o, fail_step_o);
      if (a !== e) begin
        failures++;
        $display("FAIL %s: {busy,pass,fail,code,cur,fstep} actual=%0b_%0b_%0b_%b_%0d_%0d required=%0b_%0b_%0b_%b_%0d_%0d",
                 nm, a[16], a[15], a[14], a[13:12], a[11:6], a[5:0],
                 e[16], e[15], e[14], e[13:12], e[11:6], e[5:0]);
      end
    end
  endtask

  // Output invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!wb_rst_i) begin
      checks++;
      if ((pass_o && fail_o) || (busy_o && (pass_o || fail_o))) begin
        failures++;
        $display("FAIL invariant: busy=%0b pass=%0b fail=%0b required at most one set", busy_o, pass_o, fail_o);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm();
    step_i   = '0;
    status_i = '0;
    tick(3);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
  endtask

  function automatic bit is_skip(input int k);
    return (k == 0) || (k == 4);
  endfunction

  task automatic do_step(input int k);
    step_i   = STEP_W'(k);
    status_i = 2'b11;
    tick(4);
    if (!is_skip(k)) begin
      status_i = 2'b00;
      tick(4);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [STEP_W-1:0] step;
    logic [STAT_W-1:0] stat;
    logic              busy;
    logic              pass;
    logic [STEP_W-1:0] cur;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int step, input int stat, input bit busy, input bit pass, input int cur);
    vec_t v;
    v.step = STEP_W'(step);
    v.stat = STAT_W'(stat);
    v.busy = busy;
    v.pass = pass;
    v.cur  = STEP_W'(cur);
    return v;
  endfunction

  initial begin
    vec_t v;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (is_skip(k)) begin
        vecs.push_back(mk(k, 3, 1'b1, 1'b0, k + 1));
      end else begin
        vecs.push_back(mk(k, 3, 1'b1, 1'b0, k));
        if (k == NUM_STEPS - 1) vecs.push_back(mk(k, 0, 1'b0, 1'b1, k));
        else                    vecs.push_back(mk(k, 0, 1'b1, 1'b0, k + 1));
      end
    end

    wb_rst_i = 1'b1;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    step_i   = '0;
    status_i = '0;
    tick(2);
    expect_out("reset_state", pack(0, 0, 0, 2'b00, 0, 0));
    check_out();
    #2 wb_rst_i = 1'b0;

    // Full in-order run from the table
    arm();
    expect_out("armed", pack(1, 0, 0, 2'b00, 0, 0));
    check_out();
    for (int i = 0; i < vecs.size(); i++) begin
      v        = vecs[i];
      step_i   = v.step;
      status_i = v.stat;
      expect_out($sformatf("vec%0d_step%0d", i, v.step), pack(v.busy, v.pass, 1'b0, 2'b00, v.cur, 0));
      tick(4);
      check_out();
    end

    // Timeout exactly TIMEOUT cycles after entering WAIT_STAT at step 5
    arm();
    for (int k = 0; k < 5; k++) do_step(k);
    step_i   = 6'd5;
    status_i = 2'b01;
    tick(3);
    expect_out("tmo_enter_wait_stat", pack(1, 0, 0, 2'b00, 5, 0));
    check_out();
    tick(TIMEOUT - 1);
    expect_out("tmo_one_before", pack(1, 0, 0, 2'b00, 5, 0));
    check_out();
    tick(1);
    expect_out("tmo_fired", pack(0, 0, 1, 2'b01, 5, 5));
    check_out();
    tick(5);
    expect_out("tmo_sticky", pack(0, 0, 1, 2'b01, 5, 5));
    check_out();

    // Re-arm from FAIL, then jump 2 -> 7
    arm();
    expect_out("rearm_from_fail", pack(1, 0, 0, 2'b00, 0, 0));
    check_out();
    for (int k = 0; k < 3; k++) do_step(k);
    step_i = 6'd7;
    tick(4);
`ifdef LA_STEP_STRICT_ORDER_EN
    expect_out("jump_strict_fail", pack(0, 0, 1, 2'b10, 3, 3));
    check_out();
`else
    expect_out("jump_ignored", pack(1, 0, 0, 2'b00, 3, 0));
    check_out();
    for (int i = 0; i < 2 * TIMEOUT && !fail_o; i++) tick(1);
    expect_out("jump_then_timeout", pack(0, 0, 1, 2'b01, 3, 3));
    check_out();
`endif
    pulse_abort();
    expect_out("abort_from_fail", pack(0, 0, 0, 2'b00, 0, 0));
    check_out();

    // Skip step 4 with status stuck busy, then non-skip step 5
    arm();
    for (int k = 0; k < 4; k++) do_step(k);
    step_i   = 6'd4;
    status_i = 2'b11;
    tick(4);
    expect_out("skip4_no_wait", pack(1, 0, 0, 2'b00, 5, 0));
    check_out();
    step_i = 6'd5;
    tick(4);
    expect_out("step5_waits_stat", pack(1, 0, 0, 2'b00, 5, 0));
    check_out();
    status_i = 2'b00;
    tick(4);
    expect_out("step5_done", pack(1, 0, 0, 2'b00, 6, 0));
    check_out();

    // start_i while busy has no effect
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(3);
    expect_out("start_while_busy", pack(1, 0, 0, 2'b00, 6, 0));
    check_out();

    // Async reset at step 9, then a complete rerun
    for (int k = 6; k < 9; k++) do_step(k);
    expect_out("before_reset_at9", pack(1, 0, 0, 2'b00, 9, 0));
    check_out();
    #2 wb_rst_i = 1'b1;
    #1;
    expect_out("async_reset_immediate", pack(0, 0, 0, 2'b00, 0, 0));
    check_out();
    tick(2);
    #2 wb_rst_i = 1'b0;
    arm();
    for (int k = 0; k < NUM_STEPS; k++) do_step(k);
    expect_out("rerun_pass", pack(0, 1, 0, 2'b00, 16, 0));
    check_out();

    // start_i and abort_i together in PASS
    start_i = 1'b1;
    abort_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    abort_i = 1'b0;
    expect_out("start_abort_in_pass", pack(0, 0, 0, 2'b00, 0, 0));
    check_out();
    tick(3);
    expect_out("idle_after_abort", pack(0, 0, 0, 2'b00, 0, 0));
    check_out();

    // Abort while running
    arm();
    do_step(0);
    do_step(1);
    pulse_abort();
    expect_out("abort_while_busy", pack(0, 0, 0, 2'b00, 0, 0));
    check_out();

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: actual=%0d entries required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: actual=time limit reached required=bench completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
